// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite RAM: response codes and FSM state encodings.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/byte_en_ram.sv
// Word-organised RAM with byte-lane write enables and a registered read port.
// A read and a write to the same word on one edge returns the old contents.
module byte_en_ram #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 16,
  localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         wstrb,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave RAM: independent read and write FSMs, one outstanding
// transaction per direction, SLVERR for word indices beyond MEM_DEPTH.
//
// state  | meaning
// W_IDLE | collecting AW and W, each ready drops once its beat is held
// W_RESP | write done, bvalid held until bready
// R_IDLE | arready high, waiting for an address
// R_DATA | rvalid high, rdata/rresp held until rready
module axi_lite_ram
  import axil_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 8,
  parameter int MEM_DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         awvalid,
  input  logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
  output logic                         awready,
  input  logic                         wvalid,
  input  logic [AXIL_DATA_WIDTH-1:0]   wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  output logic                         wready,
  output logic                         bvalid,
  output logic [1:0]                   bresp,
  input  logic                         bready,
  input  logic                         arvalid,
  input  logic [AXIL_ADDR_WIDTH-1:0]   araddr,
  output logic                         arready,
  output logic                         rvalid,
  output logic [AXIL_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                   rresp,
  input  logic                         rready
);

  localparam int NB       = AXIL_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = AXIL_ADDR_WIDTH - ADDR_LSB;
  localparam int RAM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(MEM_DEPTH);
  endfunction

  w_state_e                   w_state_d, w_state_q;
  logic                       awready_d, awready_q;
  logic                       wready_d, wready_q;
  logic                       aw_held_d, aw_held_q;
  logic                       w_held_d, w_held_q;
  logic [IDX_W-1:0]           aw_idx_d, aw_idx_q;
  logic [AXIL_DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [NB-1:0]              wstrb_d, wstrb_q;
  logic                       bvalid_d, bvalid_q;
  logic [1:0]                 bresp_d, bresp_q;

  r_state_e                   r_state_d, r_state_q;
  logic                       arready_d, arready_q;
  logic                       rvalid_d, rvalid_q;
  logic [1:0]                 rresp_d, rresp_q;
  logic                       rerr_d, rerr_q;

  logic                       ram_we, ram_re;
  logic [RAM_AW-1:0]          ram_waddr, ram_raddr;
  logic [AXIL_DATA_WIDTH-1:0] ram_wdata, ram_rdata;
  logic [NB-1:0]              ram_wstrb;

  logic                       aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]           aw_idx_in, ar_idx_in, wr_idx;
  logic [AXIL_DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]              wr_strb;
  logic                       wr_ok, rd_ok;
  logic                       unused_addr_lsbs;

  assign aw_hs     = awvalid & awready_q;
  assign w_hs      = wvalid & wready_q;
  assign ar_hs     = arvalid & arready_q;
  assign aw_idx_in = awaddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx_in = araddr[AXIL_ADDR_WIDTH-1:ADDR_LSB];
  assign unused_addr_lsbs = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  // Whichever beat arrives on the completing edge is taken straight from the bus.
  assign wr_idx  = aw_held_q ? aw_idx_q : aw_idx_in;
  assign wr_data = w_held_q ? wdata_q : wdata;
  assign wr_strb = w_held_q ? wstrb_q : wstrb;
  assign wr_ok   = idx_ok(wr_idx);
  assign rd_ok   = idx_ok(ar_idx_in);

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    ram_waddr = wr_idx[RAM_AW-1:0];
    ram_wdata = wr_data;
    ram_wstrb = wr_strb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = aw_idx_in;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          ram_we    = wr_ok;
        end else begin
          awready_d = ~(aw_held_q | aw_hs);
          wready_d  = ~(w_held_q | w_hs);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rerr_d    = rerr_q;
    ram_re    = 1'b0;
    ram_raddr = ar_idx_in[RAM_AW-1:0];
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          ram_re    = rd_ok;
          rerr_d    = ~rd_ok;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rerr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rerr_q    <= rerr_d;
    end
  end

  byte_en_ram #(
    .DATA_WIDTH (AXIL_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .wstrb (ram_wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rerr_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram with a transaction-level reference model
// checked against every output on every falling clock edge.
module tb_axi_lite_ram;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        awvalid = 1'b0;
  logic [7:0]  awaddr = '0;
  logic        awready;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready = 1'b1;
  logic        arvalid = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_ram #(
    .AXIL_DATA_WIDTH (32),
    .AXIL_ADDR_WIDTH (8),
    .MEM_DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .awvalid (awvalid),
    .awaddr  (awaddr),
    .awready (awready),
    .wvalid  (wvalid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wready  (wready),
    .bvalid  (bvalid),
    .bresp   (bresp),
    .bready  (bready),
    .arvalid (arvalid),
    .araddr  (araddr),
    .arready (arready),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rready  (rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction view of the slave.
  logic [31:0] m_mem [DEPTH];
  bit          m_live, m_aw_have, m_w_have, m_b_pend, m_r_pend;
  logic [7:0]  m_aw_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  function automatic bit in_rng(input logic [7:0] a);
    return (int'(a) / 4) < DEPTH;
  endfunction

  function automatic logic [3:0] widx(input logic [7:0] a);
    return a[5:2];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_live = 0; m_aw_have = 0; m_w_have = 0; m_b_pend = 0; m_r_pend = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    end else begin
      bit aw_hs, w_hs, ar_hs;
      aw_hs = awvalid && m_live && !m_aw_have && !m_b_pend;
      w_hs  = wvalid && m_live && !m_w_have && !m_b_pend;
      ar_hs = arvalid && m_live && !m_r_pend;
      if (m_r_pend && rready) m_r_pend = 0;
      if (ar_hs) begin
        m_r_pend = 1;
        if (in_rng(araddr)) begin
          m_rdata = m_mem[widx(araddr)];
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
      end
      if (m_b_pend && bready) m_b_pend = 0;
      if (aw_hs) begin m_aw_have = 1; m_aw_addr = awaddr; end
      if (w_hs)  begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if (m_aw_have && m_w_have) begin
        if (in_rng(m_aw_addr)) begin
          for (int i = 0; i < 4; i++)
            if (m_wstrb[i]) m_mem[widx(m_aw_addr)][8*i +: 8] = m_wdata[8*i +: 8];
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_b_pend = 1; m_aw_have = 0; m_w_have = 0;
      end
      m_live = 1;
    end
  end

  always @(negedge clk) begin
    chk_bit("awready", awready, m_live && !m_aw_have && !m_b_pend);
    chk_bit("wready", wready, m_live && !m_w_have && !m_b_pend);
    chk_bit("arready", arready, m_live && !m_r_pend);
    chk_bit("bvalid", bvalid, m_b_pend);
    chk_bit("rvalid", rvalid, m_r_pend);
    if (!reset) begin
      chk("rst_bresp", 32'(bresp), 32'h0);
      chk("rst_rresp", 32'(rresp), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
    end
    if (m_b_pend) chk("bresp", 32'(bresp), 32'(m_bresp));
    if (m_r_pend) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", 32'(rresp), 32'(m_rresp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All directed tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr  = addr;
      wvalid  = !w_done && cyc >= w_dly;
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      tick();
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk_bit("write_hs_done", aw_done && w_done, 1'b1);
    @(negedge clk);
    chk_bit("b_latency", bvalid, 1'b1);
    resp = bresp;
    if (bready) begin
      tick();
      @(negedge clk);
      chk_bit("b_drop", bvalid, 1'b0);
      chk_bit("awready_back", awready, 1'b1);
    end
    tick();
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit done = 0;
    int cyc = 0;
    arvalid = 1'b1;
    araddr  = addr;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (arready) done = 1;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    chk_bit("ar_hs_done", done, 1'b1);
    @(negedge clk);
    chk_bit("r_latency", rvalid, 1'b1);
    data = rdata;
    resp = rresp;
    tick();
    @(negedge clk);
    chk_bit("r_drop", rvalid, 1'b0);
    chk_bit("arready_back", arready, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_awready_lo", awready, 1'b0);
    chk_bit("rst_arready_lo", arready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("pre_edge_awready", awready, 1'b0);
    tick();
    @(negedge clk);
    chk_bit("post_edge_awready", awready, 1'b1);
    chk_bit("post_edge_wready", wready, 1'b1);
    chk_bit("post_edge_arready", arready, 1'b1);
    tick();

    for (int i = 0; i < DEPTH; i++)
      do_write(8'(i * 4), (32'h0101_0101 * i) ^ 32'h3C00_00C3, 4'hF, 0, 0, r);
    do_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    do_write(8'h0C, 32'hA5A5_A5A5, 4'hF, 0, 0, r);
    do_write(8'h1C, 32'h7777_7777, 4'hF, 0, 0, r);

    // AW and W together
    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
    chk("t1_bresp", 32'(r), 32'h0);
    do_read(8'h04, d, r);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(r), 32'h0);
    do_read(8'h07, d, r);
    chk("unaligned_rdata", d, 32'hDEAD_BEEF);

    // W three cycles ahead of AW, partial strobes
    do_write(8'h08, 32'h1122_3344, 4'b0101, 3, 0, r);
    chk("w_first_bresp", 32'(r), 32'h0);
    do_read(8'h08, d, r);
    chk("w_first_rdata", d, 32'hFF22_FF44);

    // AW two cycles ahead of W
    do_write(8'h10, 32'hCAFE_F00D, 4'b1100, 0, 2, r);
    do_read(8'h10, d, r);
    chk("aw_first_rdata", d, 32'hCAFE_04C7);

    // Out of range
    do_write(8'h40, 32'h1234_5678, 4'hF, 0, 0, r);
    chk("oor_bresp", 32'(r), 32'h2);
    do_read(8'h40, d, r);
    chk("oor_rdata", d, 32'h0);
    chk("oor_rresp", 32'(r), 32'h2);
    do_read(8'hFC, d, r);
    chk("oor_top_rresp", 32'(r), 32'h2);
    do_read(8'h00, d, r);
    chk("word0_intact", d, 32'h3C00_00C3);
    for (int i = 0; i < DEPTH; i++) do_read(8'(i * 4), d, r);

    // Stalled rready while a write proceeds
    rready = 1'b0;
    fork
      begin
        logic [1:0] wr_r;
        do_write(8'h14, 32'h55AA_55AA, 4'hF, 1, 1, wr_r);
        chk("stall_write_bresp", 32'(wr_r), 32'h0);
      end
      begin
        arvalid = 1'b1;
        araddr  = 8'h04;
        @(negedge clk);
        chk_bit("stall_ar_ready", arready, 1'b1);
        tick();
        arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk_bit("stall_rvalid", rvalid, 1'b1);
          chk("stall_rdata", rdata, 32'hDEAD_BEEF);
          chk_bit("stall_arready", arready, 1'b0);
          tick();
        end
        rready = 1'b1;
        @(negedge clk);
        chk_bit("stall_rvalid_end", rvalid, 1'b1);
        tick();
        @(negedge clk);
        chk_bit("stall_rvalid_drop", rvalid, 1'b0);
        tick();
      end
    join
    do_read(8'h14, d, r);
    chk("stall_write_data", d, 32'h55AA_55AA);

    // Same-word read and write on one edge
    awvalid = 1'b1; awaddr = 8'h0C;
    wvalid  = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 8'h0C;
    @(negedge clk);
    chk_bit("same_edge_ready", awready && wready && arready, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("same_edge_old", rdata, 32'hA5A5_A5A5);
    chk_bit("same_edge_bvalid", bvalid, 1'b1);
    tick();
    tick();
    do_read(8'h0C, d, r);
    chk("same_edge_new", d, 32'h5A5A_5A5A);

    // Reset with a pending write response and a pending read
    bready = 1'b0;
    do_write(8'h18, 32'h600D_600D, 4'hF, 0, 0, r);
    rready = 1'b0;
    arvalid = 1'b1; araddr = 8'h04;
    tick();
    arvalid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk_bit("mid_rst_bvalid", bvalid, 1'b0);
    chk_bit("mid_rst_rvalid", rvalid, 1'b0);
    chk_bit("mid_rst_awready", awready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    @(negedge clk);
    chk_bit("rel_awready", awready, 1'b1);
    chk_bit("rel_wready", wready, 1'b1);
    chk_bit("rel_arready", arready, 1'b1);
    tick();
    do_read(8'h18, d, r);
    chk("pre_rst_write_kept", d, 32'h600D_600D);

    // Reset with only the W beat captured
    wvalid = 1'b1; wdata = 32'hBAD0_BAD0; wstrb = 4'hF;
    @(negedge clk);
    chk_bit("half_w_ready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk_bit("half_w_held", wready, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    awvalid = 1'b1; awaddr = 8'h1C;
    @(negedge clk);
    tick();
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_bit("half_no_bvalid", bvalid, 1'b0);
      tick();
    end
    do_read(8'h1C, d, r);
    chk("half_write_unchanged", d, 32'h7777_7777);
    wvalid = 1'b1; wdata = 32'h1212_1212; wstrb = 4'hF;
    @(negedge clk);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk_bit("late_w_bvalid", bvalid, 1'b1);
    chk("late_w_bresp", 32'(bresp), 32'h0);
    tick();
    tick();
    do_read(8'h1C, d, r);
    chk("late_w_data", d, 32'h1212_1212);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_ram.md
# axi_lite_ram

Parametrised AXI4-Lite slave RAM: word-organised memory with byte addressing, byte-lane write strobes, full VALID/READY handshakes on all five channels, and OKAY/SLVERR responses for in-range/out-of-range accesses. It is the general-purpose register and scratch memory behind the AXI4-Lite interconnect. Read and write channels operate independently, with one outstanding transaction per direction.

## Interface
- AXIL_DATA_WIDTH, 32: data bus width; 32 or 64.
- AXIL_ADDR_WIDTH, 8: byte address width.
- MEM_DEPTH, 16: number of words; must be ≤ 2^(AXIL_ADDR_WIDTH − ADDR_LSB).
- Derived (localparam): ADDR_LSB = log2(AXIL_DATA_WIDTH/8).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- awvalid  in  1;  awaddr  in  AXIL_ADDR_WIDTH;  awready  out  1 : write address channel.
- wvalid  in  1;  wdata  in  AXIL_DATA_WIDTH;  wstrb  in  AXIL_DATA_WIDTH/8;  wready  out  1 : write data channel.
- bvalid  out  1;  bresp  out  2;  bready  in  1 : write response channel.
- arvalid  in  1;  araddr  in  AXIL_ADDR_WIDTH;  arready  out  1 : read address channel.
- rvalid  out  1;  rdata  out  AXIL_DATA_WIDTH;  rresp  out  2;  rready  in  1 : read data channel.

## Operation
- Word index = addr[AXIL_ADDR_WIDTH-1:ADDR_LSB]; addr[ADDR_LSB-1:0] is ignored, so unaligned addresses are treated as aligned.
- Index ≥ MEM_DEPTH is out of range:
  - Write: suppressed, bresp = SLVERR (2'b10).
  - Read: rdata = 0, rresp = SLVERR.
- In range: response is OKAY (2'b00).
- Write FSM:
  - W_IDLE: awready = 1 and wready = 1.
  - Each channel is captured independently on its own handshake, and its ready drops after capture.
  - When both address and data are held, move to W_RESP. The memory write happens on that transition edge.
  - Byte lane i is written only if wstrb[i] = 1.
  - W_RESP: bvalid = 1 until bready; then W_IDLE.
- Read FSM:
  - R_IDLE: arready = 1. On the AR handshake, the word is read into rdata and the FSM moves to R_DATA.
  - R_DATA: rvalid = 1 and rdata/rresp are held stable until rready; then R_IDLE.
- Same-word read and write on the same edge: read returns the pre-write contents.
- Memory contents are not affected by reset. Only control and state registers reset.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - awready, wready, arready = 1 from the first edge after release; 0 while reset is low.
  - bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0.
  - Both FSMs go to IDLE.
- Reset mid-transaction aborts it. A write whose second handshake has not completed leaves memory unchanged.
- Read latency: AR handshake at edge N gives rvalid = 1 after edge N. With rready held at 1, rvalid drops after edge N+1 and arready returns. Sustained read throughput is 1 transaction per 2 cycles.
- Write latency: the edge completing the later of AW/W sets bvalid. With bready = 1, bvalid drops on the next edge, and awready/wready return after it.
- AW before W, W before AW, and both in the same cycle all produce identical memory and response results.
- VALID/READY: once asserted, bvalid/rvalid and their payloads stay stable until the handshake. Readies never depend combinationally on valids (all registered).
- Stalled bready/rready blocks only its own channel; the other direction continues.

## Structure
- Shared package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Write FSM state encodings W_IDLE/W_RESP; read FSM state encodings R_IDLE/R_DATA.
- One sub-module, byte_en_ram:
  - DATA_WIDTH/DEPTH parameters.
  - Synchronous byte-lane-enabled write port.
  - Synchronous read port with read-before-write semantics.
- Top level holds both FSMs, address decode and range check.

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with wstrb = 4'hF (AW and W same cycle) → bresp = OKAY one edge later. Read 0x04 → rdata = 0xDEADBEEF, rresp = OKAY.
- W handshake 3 cycles before AW, wdata = 0x11223344, wstrb = 4'b0101 at 0x08 over prior 0xFFFFFFFF → read returns 0xFF22FF44.
- Write or read at 0x40 with MEM_DEPTH = 16 → bresp = SLVERR and no memory word changed. Read gives rdata = 0, rresp = SLVERR.
- Hold rready = 0 for 5 cycles after the AR handshake → rvalid and rdata stable, arready = 0 throughout. A concurrent write completes with bvalid.
- Read and write 0x0C on the same edge (old value 0xA5A5A5A5, new 0x5A5A5A5A) → read returns 0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A.
- Assert reset low with bvalid pending and a half-captured write → all valids 0 immediately, readies 1 after release, and the half-captured write leaves memory unchanged.
